tty_mmio_port: RTL and testbench

//  Memory-mapped TTY port controller between the MIPS data bus (chip-select decoded) and the tty

---
 rtl/tty_mmio_pkg.sv | 46 ++++
 rtl/tty_mmio_if.sv | 21 ++
 rtl/tty_mmio_sync2.sv | 30 +++
 rtl/tty_mmio_port.sv | 207 ++++++++++++++++++++
 tb/tb_tty_mmio_port.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tty_mmio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : tty_mmio_pkg                                              |
// | Purpose   : Shared register map, bit indices and FSM state types for  |
// |             the memory-mapped TTY port controller.                    |
// | Revision  : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package tty_mmio_pkg;

  // Word offsets of the CPU-visible registers
  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_RXDATA  = 2'd1;
  localparam logic [1:0] ADDR_TXDATA  = 2'd2;
  localparam logic [1:0] ADDR_CONTROL = 2'd3;

  // STATUS bit positions
  localparam int STAT_RX_VALID = 0;
  localparam int STAT_TX_BUSY  = 1;
  localparam int STAT_OVERRUN  = 2;

  // CONTROL bit positions (bits 2:1 = {ie_tx, ie_rx})
  localparam int CTRL_RX_EN = 0;
  localparam int CTRL_IE_RX = 1;
  localparam int CTRL_IE_TX = 2;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_WAIT   = 2'd1,
    RX_SETTLE = 2'd2,
    RX_DRAIN  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE     = 2'd0,
    TX_SETUP    = 2'd1,
    TX_STROBE   = 2'd2,
    TX_WAIT_DTR = 2'd3
  } tx_state_t;

  // Width of a counter that has to reach n-1
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tty_mmio_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : tty_mmio_if                                               |
// | Purpose   : Chip-select decoded CPU data-bus slice seen by the TTY    |
// |             port: select, direction, word offset, data and irq.       |
// | Revision  : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface tty_mmio_if;
  logic        cs;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output cs, output we, output addr, output wdata,
                  input rdata, input irq);
  modport slave  (input cs, input we, input addr, input wdata,
                  output rdata, output irq);
endinterface
`default_nettype wire

// File: rtl/tty_mmio_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tty_sync2                                                 |
// | Purpose   : Two-flop synchroniser with synchronous reset for one      |
// |             asynchronous terminal handshake line.                     |
// | Revision  : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tty_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule
`default_nettype wire

// File: rtl/tty_mmio_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tty_mmio_port                                             |
// | Purpose   : Memory-mapped TTY port: RX handshake (CTS/RTS/TD) and TX  |
// |             handshake (RD/DSR/DTR) behind STATUS/RXDATA/TXDATA/CONTROL|
// | Macro     : TTY_IRQ_EN enables irq, the ie_* CONTROL bits and the     |
// |             STATUS overrun flag.                                      |
// | Revision  : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tty_mmio_port
  import tty_mmio_pkg::*;
#(
  parameter int SETTLE_CYC = 10,  // TD capture delay after sync RTS rise; 10 is the safe minimum
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  tty_mmio_if.slave  bus,
  input  logic [7:0] tty_td,
  input  logic       tty_rts,
  output logic       tty_cts,
  output logic [7:0] tty_rd,
  output logic       tty_dsr,
  input  logic       tty_dtr
);

  localparam int RX_CW = cnt_width(SETTLE_CYC);
  localparam int TX_CW = cnt_width((SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC);

  logic             rts_s, dtr_s, rts_prev_q, rts_rise;
  rx_state_t        rx_state_q, rx_state_d;
  logic [RX_CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  tx_state_t        tx_state_q, tx_state_d;
  logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]       rd_q, rd_d;
  logic [2:0]       ctl_q, ctl_d;
  logic             overrun_q, overrun_d;
  logic             irq_q, irq_d;
  logic             rd_status, rd_rxdata, wr_txdata, wr_control;
  logic             tx_busy, rx_en;
  logic [31:0]      rdata_w;
  logic             unused_wdata;

  tty_sync2 u_sync_rts (.clk(clk), .reset(reset), .d(tty_rts), .q(rts_s));
  tty_sync2 u_sync_dtr (.clk(clk), .reset(reset), .d(tty_dtr), .q(dtr_s));

  assign rd_status    = bus.cs & ~bus.we & (bus.addr == ADDR_STATUS);
  assign rd_rxdata    = bus.cs & ~bus.we & (bus.addr == ADDR_RXDATA);
  assign wr_txdata    = bus.cs &  bus.we & (bus.addr == ADDR_TXDATA);
  assign wr_control   = bus.cs &  bus.we & (bus.addr == ADDR_CONTROL);
  assign rts_rise     = rts_s & ~rts_prev_q;
  assign tx_busy      = (tx_state_q != TX_IDLE);
  assign rx_en        = ctl_q[CTRL_RX_EN];
  assign unused_wdata = ^bus.wdata[31:1];

  // RX handshake: arm CTS, wait for RTS, let TD settle, capture, wait for RTS release
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    if (rd_rxdata) rx_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_en && !rx_valid_q) rx_state_d = RX_WAIT;
      end
      RX_WAIT: begin
        if (!rx_en) begin
          rx_state_d = RX_IDLE;
        end else if (rts_rise) begin
          // The cycle in which the synchronised rise is seen counts as the first settle cycle
          rx_state_d = RX_SETTLE;
          rx_cnt_d   = RX_CW'(1);
        end
      end
      RX_SETTLE: begin
        if (rx_cnt_q == RX_CW'(SETTLE_CYC - 1)) begin
          rx_data_d  = tty_td;
          rx_valid_d = 1'b1;  // overrides a coincident RXDATA read
          rx_state_d = RX_DRAIN;
        end else begin
          rx_cnt_d = rx_cnt_q + RX_CW'(1);
        end
      end
      RX_DRAIN: begin
        if (!rts_s) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // TX handshake: present RD, hold for setup, strobe DSR, wait for terminal DTR
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    rd_d       = rd_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (wr_txdata) begin
          rd_d       = bus.wdata[7:0];
          tx_cnt_d   = '0;
          tx_state_d = TX_SETUP;
        end
      end
      TX_SETUP: begin
        if (tx_cnt_q == TX_CW'(SETUP_CYC - 1)) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_STROBE;
        end else begin
          tx_cnt_d = tx_cnt_q + TX_CW'(1);
        end
      end
      TX_STROBE: begin
        if (tx_cnt_q == TX_CW'(STROBE_CYC - 1)) begin
          tx_state_d = TX_WAIT_DTR;
        end else begin
          tx_cnt_d = tx_cnt_q + TX_CW'(1);
        end
      end
      TX_WAIT_DTR: begin
        if (dtr_s) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // CONTROL register; interrupt enables only exist in the irq build
  always_comb begin
    ctl_d = ctl_q;
    if (wr_control) begin
      ctl_d[CTRL_RX_EN] = bus.wdata[CTRL_RX_EN];
`ifdef TTY_IRQ_EN
      ctl_d[CTRL_IE_RX] = bus.wdata[CTRL_IE_RX];
      ctl_d[CTRL_IE_TX] = bus.wdata[CTRL_IE_TX];
`endif
    end
  end

  // Overrun flag and registered interrupt; both stay zero without TTY_IRQ_EN
  always_comb begin
    overrun_d = 1'b0;
    irq_d     = 1'b0;
`ifdef TTY_IRQ_EN
    overrun_d = overrun_q;
    if (rd_status) overrun_d = 1'b0;
    if ((rx_state_q == RX_IDLE) && rts_rise && rx_valid_q) overrun_d = 1'b1;
    irq_d = (rx_valid_q & ctl_q[CTRL_IE_RX]) | (~tx_busy & ctl_q[CTRL_IE_TX]);
`endif
  end

  // Read mux, purely a function of the word offset
  always_comb begin
    rdata_w = '0;
    case (bus.addr)
      ADDR_STATUS:  begin
        rdata_w[STAT_RX_VALID] = rx_valid_q;
        rdata_w[STAT_TX_BUSY]  = tx_busy;
        rdata_w[STAT_OVERRUN]  = overrun_q;
      end
      ADDR_RXDATA:  rdata_w[7:0] = rx_data_q;
      ADDR_TXDATA:  rdata_w[7:0] = rd_q;
      ADDR_CONTROL: rdata_w[2:0] = ctl_q;
      default:      rdata_w = '0;
    endcase
  end

  // State registers; reset aborts any transfer in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      rts_prev_q <= 1'b0;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      rd_q       <= 8'h00;
      ctl_q      <= 3'b000;
      overrun_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rts_prev_q <= rts_s;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      rd_q       <= rd_d;
      ctl_q      <= ctl_d;
      overrun_q  <= overrun_d;
      irq_q      <= irq_d;
    end
  end

  // CTS stays up through settling and drops together with the capture
  assign tty_cts   = (rx_state_q == RX_WAIT) || (rx_state_q == RX_SETTLE);
  assign tty_dsr   = (tx_state_q == TX_STROBE);
  assign tty_rd    = rd_q;
  assign bus.rdata = rdata_w;
  assign bus.irq   = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_tty_mmio_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_tty_mmio_port                                          |
// | Purpose   : Self-checking bench for tty_mmio_port: register table,    |
// |             RX/TX handshakes, stalls, mid-transfer reset and irq.     |
// | Revision  : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_tty_mmio_port;
`ifdef TTY_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tty_td = 8'h00;
  logic       tty_rts = 1'b0;
  logic       tty_dtr = 1'b0;
  logic       tty_cts, tty_dsr;
  logic [7:0] tty_rd;

  tty_mmio_if bus();

  tty_mmio_port #(.SETTLE_CYC(10), .SETUP_CYC(2), .STROBE_CYC(2)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .tty_td(tty_td), .tty_rts(tty_rts), .tty_cts(tty_cts),
    .tty_rd(tty_rd), .tty_dsr(tty_dsr), .tty_dtr(tty_dtr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct { string name; logic [31:0] exp; } sb_t;
  sb_t sbq[$];

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vtab[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_push(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sbq.push_back(e);
  endtask

  task automatic sb_pop();
    sb_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = sbq.pop_front();
      chk(e.name, bus.rdata, e.exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    tick();
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
    sb_push(name, exp);
    #2;
    sb_pop();
    tick();
    bus.cs = 1'b0;
  endtask

  task automatic wait_cts(input string name, input logic exp);
    int n = 0;
    while (tty_cts !== exp && n < 40) begin
      tick();
      n++;
    end
    chk(name, {31'b0, tty_cts}, {31'b0, exp});
  endtask

  task automatic set_vec(input int i, input string name, input logic we, input logic [1:0] a,
                         input logic [31:0] d, input logic [31:0] e);
    vtab[i].name = name; vtab[i].we = we; vtab[i].addr = a; vtab[i].wdata = d; vtab[i].exp = e;
  endtask

  initial begin
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 32'h0;
    set_vec(0,  "rst_status",  1'b0, 2'd0, 32'h0,        32'h0);
    set_vec(1,  "rst_rxdata",  1'b0, 2'd1, 32'h0,        32'h0);
    set_vec(2,  "rst_txdata",  1'b0, 2'd2, 32'h0,        32'h0);
    set_vec(3,  "rst_control", 1'b0, 2'd3, 32'h0,        32'h0);
    set_vec(4,  "",            1'b1, 2'd0, 32'hFF,       32'h0);
    set_vec(5,  "status_ro",   1'b0, 2'd0, 32'h0,        32'h0);
    set_vec(6,  "",            1'b1, 2'd1, 32'h55,       32'h0);
    set_vec(7,  "rxdata_ro",   1'b0, 2'd1, 32'h0,        32'h0);
    set_vec(8,  "",            1'b1, 2'd3, 32'h6,        32'h0);
    set_vec(9,  "ctl_ie_bits", 1'b0, 2'd3, 32'h0,        IRQ_ON ? 32'h6 : 32'h0);
    set_vec(10, "",            1'b1, 2'd3, 32'hFFFFFFF8, 32'h0);
    set_vec(11, "ctl_upper",   1'b0, 2'd3, 32'h0,        32'h0);

    // Reset state of the pins
    tick(); tick();
    chk("rst_cts", {31'b0, tty_cts}, 32'h0);
    chk("rst_dsr", {31'b0, tty_dsr}, 32'h0);
    chk("rst_rd",  {24'b0, tty_rd},  32'h0);
    chk("rst_irq", {31'b0, bus.irq}, 32'h0);
    reset = 1'b0;
    tick();

    // Register map table
    for (int i = 0; i < 12; i++) begin
      if (vtab[i].we) bus_write(vtab[i].addr, vtab[i].wdata);
      else            bus_read(vtab[i].name, vtab[i].addr, vtab[i].exp);
    end

    // Receive: capture lands exactly 2+SETTLE_CYC edges after RTS is driven
    bus_write(2'd3, 32'h1);
    tick();
    chk("cts_rx_en", {31'b0, tty_cts}, 32'h1);
    tty_td = 8'h41; tty_rts = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 11) chk("cts_before_capture", {31'b0, tty_cts}, 32'h1);
      if (k == 12) chk("cts_at_capture", {31'b0, tty_cts}, 32'h0);
    end
    bus_read("status_full", 2'd0, 32'h1);
    bus_read("rx_41", 2'd1, 32'h41);
    bus_read("status_empty", 2'd0, 32'h0);

    // Back-pressure: full buffer blocks a second character
    tty_rts = 1'b0;
    repeat (4) tick();
    chk("cts_rearm", {31'b0, tty_cts}, 32'h1);
    tty_rts = 1'b1;
    wait_cts("bp_capture", 1'b0);
    repeat (3) tick();
    chk("bp_hold_high", {31'b0, tty_cts}, 32'h0);
    tty_rts = 1'b0;
    repeat (4) tick();
    tty_td = 8'h42; tty_rts = 1'b1;
    repeat (4) tick();
    chk("bp_cts_low", {31'b0, tty_cts}, 32'h0);
    bus_read("bp_status_ovr", 2'd0, IRQ_ON ? 32'h5 : 32'h1);
    bus_read("bp_status_clr", 2'd0, 32'h1);
    bus_read("bp_rx_41", 2'd1, 32'h41);
    tick();
    chk("bp_cts_resume", {31'b0, tty_cts}, 32'h1);
    tty_rts = 1'b0;
    repeat (3) tick();
    tty_rts = 1'b1;
    wait_cts("bp_capture2", 1'b0);
    bus_read("bp_rx_42", 2'd1, 32'h42);

    // Transmit with DTR already high; write during busy is dropped
    tty_dtr = 1'b1;
    repeat (3) tick();
    bus_write(2'd2, 32'h61);
    chk("tx_rd", {24'b0, tty_rd}, 32'h61);
    chk("tx_dsr_c1", {31'b0, tty_dsr}, 32'h0);
    for (int k = 2; k <= 6; k++) begin
      if (k == 2) begin
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 2'd2; bus.wdata = 32'h62;
      end
      tick();
      bus.cs = 1'b0; bus.we = 1'b0;
      chk($sformatf("tx_dsr_c%0d", k), {31'b0, tty_dsr}, (k == 3 || k == 4) ? 32'h1 : 32'h0);
    end
    chk("tx_rd_hold", {24'b0, tty_rd}, 32'h61);
    bus_read("tx_idle_status", 2'd0, 32'h0);
    bus_read("tx_rdback", 2'd2, 32'h61);

    // DTR stall holds busy until the synchronised DTR rises
    tty_dtr = 1'b0;
    repeat (3) tick();
    bus_write(2'd2, 32'h70);
    chk("stall_rd", {24'b0, tty_rd}, 32'h70);
    repeat (30) tick();
    bus_read("stall_busy", 2'd0, 32'h2);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 2'd0;
    tty_dtr = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 1) begin sb_push("dtr_busy_c1", 32'h2); sb_pop(); end
      if (k == 3) begin sb_push("dtr_clear_c3", 32'h0); sb_pop(); end
    end
    bus.cs = 1'b0;

    // Reset during RX_SETTLE
    tty_rts = 1'b0;
    repeat (4) tick();
    chk("rst_pre_wait", {31'b0, tty_cts}, 32'h1);
    tty_td = 8'h99; tty_rts = 1'b1;
    repeat (6) tick();
    chk("rst_in_settle", {31'b0, tty_cts}, 32'h1);
    reset = 1'b1;
    tick();
    chk("rst_mid_cts", {31'b0, tty_cts}, 32'h0);
    chk("rst_mid_rd",  {24'b0, tty_rd},  32'h0);
    reset = 1'b0;
    bus_read("rst_mid_status", 2'd0, 32'h0);
    bus_read("rst_mid_rxdata", 2'd1, 32'h0);
    bus_read("rst_mid_ctl", 2'd3, 32'h0);
    repeat (15) tick();
    chk("rst_no_cts", {31'b0, tty_cts}, 32'h0);
    bus_read("rst_no_capture", 2'd0, 32'h0);

    // Interrupt behaviour (constant zero without the irq build)
    tty_rts = 1'b0;
    repeat (4) tick();
    bus_write(2'd3, 32'h7);
    tick();
    chk("irq_tx_idle", {31'b0, bus.irq}, {31'b0, IRQ_ON});
    bus_read("irq_ctl", 2'd3, IRQ_ON ? 32'h7 : 32'h1);
    tty_td = 8'h41; tty_rts = 1'b1;
    wait_cts("irq_capture", 1'b0);
    tick();
    chk("irq_rx_full", {31'b0, bus.irq}, {31'b0, IRQ_ON});
    tty_rts = 1'b0;
    repeat (4) tick();
    tty_rts = 1'b1;
    repeat (4) tick();
    bus_read("irq_ovr_set", 2'd0, IRQ_ON ? 32'h5 : 32'h1);
    bus_read("irq_ovr_clr", 2'd0, 32'h1);
    bus_read("irq_rx_41", 2'd1, 32'h41);
    bus_write(2'd3, 32'h4);
    tty_dtr = 1'b0;
    repeat (3) tick();
    bus_write(2'd2, 32'h33);
    repeat (2) tick();
    chk("irq_tx_busy", {31'b0, bus.irq}, 32'h0);
    tty_dtr = 1'b1;
    repeat (5) tick();
    chk("irq_tx_done", {31'b0, bus.irq}, {31'b0, IRQ_ON});
    chk("irq_tx_rd", {24'b0, tty_rd}, 32'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
